// File: rtl/oars_pkg.sv
// Shared constants for the OARS scroller: glyphs, message, position width and run/pause state.
// glyph_at maps (position, digit index) onto the rotating message.
package oars_pkg;

  localparam int NPOS  = 6;
  localparam int POS_W = 3;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NPOS - 1);

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [0:6] GLYPH_BLANK = 7'b1111111;
  localparam logic [0:6] GLYPH_O     = 7'b0000001;
  localparam logic [0:6] GLYPH_A     = 7'b0001000;
  localparam logic [0:6] GLYPH_R     = 7'b1111010;
  localparam logic [0:6] GLYPH_S     = 7'b0100100;

  localparam logic [0:6] M [0:NPOS-1] = '{GLYPH_BLANK, GLYPH_O, GLYPH_A,
                                         GLYPH_R, GLYPH_S, GLYPH_BLANK};

  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  // Digit k (H5 is leftmost) shows message entry (5 - k + p) mod 6.
  function automatic logic [0:6] glyph_at(input logic [POS_W-1:0] p, input int k);
    logic [3:0] s;
    s = 4'(NPOS - 1 - k) + {1'b0, p};
    if (s >= 4'(NPOS)) s = s - 4'(NPOS);
    return M[s[2:0]];
  endfunction

endpackage

// File: rtl/oars_scroll_ctrl_tick_gen.sv
// Scroll-rate divider: counts 0..TICK_DIV-1 while enabled and flags the last count.
// Disabled means the count is forced back to zero, so a restart always begins a full period.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic Resetn,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tick    = en && (count_q == LAST);
    count_d = '0;
    if (en && !tick) count_d = count_q + CW'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/oars_scroll_ctrl.sv
// OARS six-digit scroller: button synchronizer, run/pause FSM, wrap-around position
// counter and registered segment drivers that load from the next position.
module oars_scroll_ctrl
  import oars_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             CLOCK_50,
  input  logic             Resetn,
  input  logic             run,
  input  logic             dir,
  input  logic             step_n,
  output logic [POS_W-1:0] pos,
  output logic [0:6]       H0,
  output logic [0:6]       H1,
  output logic [0:6]       H2,
  output logic [0:6]       H3,
  output logic [0:6]       H4,
  output logic [0:6]       H5
);

  logic sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
  logic step_pulse, tick, advance;
  state_e state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [NPOS-1:0][0:6] h_q, h_d, h_rst;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .en       (state_q == ST_RUN),
    .tick     (tick)
  );

  // Valid step request: one-cycle pulse on the synchronized falling edge of step_n.
  always_comb begin
    sync1_d    = step_n;
    sync2_d    = sync1_q;
    edge_d     = sync2_q;
    step_pulse = edge_q && !sync2_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSED: if (run)  state_d = ST_RUN;
      ST_RUN:    if (!run) state_d = ST_PAUSED;
      default:   state_d = ST_PAUSED;
    endcase
  end

  always_comb begin
    advance = (state_q == ST_RUN) ? tick : step_pulse;
    pos_d   = pos_q;
    if (advance) begin
      if (dir) pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
      else     pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
    end
  end

  // Segments load from pos_d so they change on the same edge as pos.
  for (genvar k = 0; k < NPOS; k++) begin : g_dig
    assign h_d[k]   = glyph_at(pos_d, k);
    assign h_rst[k] = glyph_at(POS_W'(0), k);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
      state_q <= ST_PAUSED;
      pos_q   <= '0;
      h_q     <= h_rst;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
      state_q <= state_d;
      pos_q   <= pos_d;
      h_q     <= h_d;
    end
  end

  assign pos = pos_q;
  assign H0  = h_q[0];
  assign H1  = h_q[1];
  assign H2  = h_q[2];
  assign H3  = h_q[3];
  assign H4  = h_q[4];
  assign H5  = h_q[5];

endmodule

// File: doc/oars_scroll_ctrl.md
Name: oars_scroll_ctrl

Overview:
- Sequencer for the six-digit "OARS" seven-segment display (H5..H0).
- Replaces manual switch selection of the rotation position with a free-running or single-step scroll.
- Provides a tick divider, a wrap-around position counter, a run/pause FSM and registered segment drivers.
- Sits between board switches/keys and the HEX outputs.

Parameters:
- TICK_DIV, 50_000_000: CLOCK_50 cycles per scroll step; must be ≥2. Benches use 4.
- NPOS, 6: number of rotation positions, equal to the number of digits. Fixed; not to be overridden.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- Resetn  in  1  synchronous active-low reset.
- run  in  1  level; 1 = auto-scroll, 0 = pause.
- dir  in  1  0 = scroll left, 1 = scroll right.
- step_n  in  1  raw active-low pushbutton, asynchronous to CLOCK_50.
- pos  out  3  current rotation position, 0..5.
- H0..H5  out  [0:6] each  active-low segments, a..g.

Behaviour:
- Glyphs (active-low [0:6]): BLANK=1111111, O=0000001, A=0001000, R=1111010, S=0100100.
- Message M[0..5] left to right = BLANK,O,A,R,S,BLANK.
- Digit Hk shows M[(5-k+pos) mod 6].
  - pos=0: H5..H0 = BLANK,O,A,R,S,BLANK.
  - pos=1: H5..H0 = O,A,R,S,BLANK,BLANK.
- Reset (Resetn=0 at a clock edge):
  - pos=0, tick counter=0, state=PAUSED.
  - sync/edge flops = 1 (released button).
  - H outputs = pos-0 pattern on the same edge.
- step_n path:
  - 2-flop synchronizer, then falling-edge detect.
  - step_pulse is 1 cycle wide, 3 cycles after the step_n fall.
  - Holding the button gives exactly one pulse.
- Tick counter:
  - Counts 0..TICK_DIV-1 only in RUN; tick=1 when count==TICK_DIV-1, then wraps to 0.
  - Held at 0 in PAUSED.
- FSM:
  - PAUSED -> RUN when run=1, tick counter restarts at 0.
  - RUN -> PAUSED when run=0, counter cleared.
  - No other states.
- Advance event: tick in RUN, or step_pulse in PAUSED.
  - step_pulse in RUN is ignored.
  - A tick is impossible in PAUSED.
- On advance:
  - dir=0: pos = pos==5 ? 0 : pos+1.
  - dir=1: pos = pos==0 ? 5 : pos-1.
  - dir is sampled at the advance edge only; changing dir between advances does not move pos.
- Latency:
  - H outputs are registered from next-pos, so they update on the same edge as pos (zero cycles relative to pos).
  - First auto step occurs TICK_DIV cycles after entering RUN.
- Simultaneous run falling and tick in the same cycle: the state is still RUN, so the advance happens; PAUSED from the next cycle.
- Reset mid-scroll: an immediate return to the reset values above, with no partial step.
- pos is never 6 or 7.

Decomposition:
- Package oars_pkg:
  - glyph localparams GLYPH_BLANK/O/A/R/S (7-bit).
  - message array constant M.
  - POS_W=3, NPOS=6.
  - state encoding ST_PAUSED=0, ST_RUN=1.
- Sub-module tick_gen (parameter TICK_DIV; ports CLOCK_50, Resetn, en, tick).
- Synchronizer, FSM, position counter and glyph mux stay in the top.

Test Plan (TICK_DIV=4):
- Reset: hold Resetn=0 for 2 cycles.
  - Required: pos=0; H5..H0 = 1111111, 0000001, 0001000, 1111010, 0100100, 1111111.
  - Outputs stay there with run=0 and no step.
- Auto-scroll left: run=1, dir=0 for 28 cycles.
  - Required: pos goes 1,2,3,4,5,0,1, advancing every 4th cycle after run rises.
  - At pos=1: H0 = 1111111 and H5 = 0000001.
- Right wrap: from pos=0, run=1, dir=1.
  - Required: first tick gives pos=5, H5..H0 = BLANK,BLANK,O,A,R,S; next tick gives pos=4.
- Single step: run=0; pulse step_n low for 10 cycles, three times, with gaps.
  - Required: pos advances exactly 0→1→2→3, each change 3 cycles after the fall.
  - step_n pulses while run=1 cause no extra advance.
- Pause mid-count: run=1 for 3 cycles, run=0 for 5 cycles, run=1.
  - Required: pos unchanged until 4 cycles after the second run rise.
- Reset mid-operation: at pos=3 with run=1, Resetn=0 for 1 cycle.
  - Required: pos=0 and the pos-0 pattern on that edge.
  - No advance for 4 cycles after release, even with run=1 (FSM re-enters RUN from PAUSED).
